// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR receiver: FSM states, pulse windows in
// microseconds, and the window-compare helper used by the decoder.
package nec_ir_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LEAD_LOW  = 3'd1,
      LEAD_HIGH = 3'd2,
      BIT_LOW   = 3'd3,
      BIT_HIGH  = 3'd4,
      STOP_LOW  = 3'd5,
      RPT_LOW   = 3'd6
   } nec_state_t;

   localparam int unsigned LEAD_LO_MIN = 8000;
   localparam int unsigned LEAD_LO_MAX = 10000;
   localparam int unsigned LEAD_HI_MIN = 4000;
   localparam int unsigned LEAD_HI_MAX = 5000;
   localparam int unsigned RPT_HI_MIN  = 2000;
   localparam int unsigned RPT_HI_MAX  = 2500;
   localparam int unsigned BURST_MIN   = 400;
   localparam int unsigned BURST_MAX   = 700;
   localparam int unsigned ONE_HI_MIN  = 1400;
   localparam int unsigned ONE_HI_MAX  = 1900;
   localparam int unsigned TIMEOUT_US  = 12000;

   // Inclusive window test; bounds are in microseconds, scaled to cycles here.
   function automatic logic in_win(input logic [31:0] cnt,
                                   input int unsigned lo_us,
                                   input int unsigned hi_us,
                                   input int unsigned cyc_per_us);
      return (cnt >= lo_us * cyc_per_us) && (cnt <= hi_us * cyc_per_us);
   endfunction

endpackage

// File: rtl/nec_ir_receiver_sync_edge.sv
// Two-flop synchroniser for the asynchronous IR pin plus a third flop that
// turns level changes into single-cycle fall/rise pulses.
module ir_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic fall,
   output logic rise,
   output logic level
);

   logic s1, s2, s3;

   // All three flops reset high so leaving reset on an idle line is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= din;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign fall  = s3 & ~s2;
   assign rise  = ~s3 & s2;
   assign level = s2;

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR decoder: measures each pulse on the synchronised pin and walks the
// leader / 32-bit / stop (or repeat) sequence, emitting one-cycle strobes.
module nec_ir_receiver
   import nec_ir_pkg::*;
#(
   parameter int unsigned CYC_PER_US = 50,
   parameter int unsigned CHECK_INV  = 1,
   parameter int unsigned CNT_W      = 20
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iIRDA,
   output logic [31:0] oDATA,
   output logic        oVALID,
   output logic        oREPEAT,
   output logic        oERR,
   output logic        oBUSY
);

   logic             ir_fall, ir_rise, ir_level;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      cnt32;
   nec_state_t       state, state_nx;
   logic [31:0]      sh, sh_nx;
   logic [4:0]       idx, idx_nx;
   logic             held;
   logic             valid_nx, rpt_nx, err_nx, load;
   logic             inv_ok, timeout;

   ir_sync_edge u_sync (
      .clk   (iCLK),
      .rst   (iRST),
      .din   (iIRDA),
      .fall  (ir_fall),
      .rise  (ir_rise),
      .level (ir_level)
   );

   // Phase length since the last edge; parks at all-ones on a quiet line.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST)
         cnt <= '0;
      else if (ir_fall || ir_rise)
         cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})
         cnt <= cnt + 1'b1;
   end

   assign cnt32   = 32'(cnt);
   assign timeout = cnt32 > TIMEOUT_US * CYC_PER_US;
   assign inv_ok  = (sh[15:8] == ~sh[7:0]) && (sh[31:24] == ~sh[23:16]);

   always_comb begin
      state_nx = state;
      sh_nx    = sh;
      idx_nx   = idx;
      valid_nx = 1'b0;
      rpt_nx   = 1'b0;
      err_nx   = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            if (ir_fall && !ir_level)
               state_nx = LEAD_LOW;
         end
         LEAD_LOW: begin
            if (ir_rise) begin
               if (in_win(cnt32, LEAD_LO_MIN, LEAD_LO_MAX, CYC_PER_US))
                  state_nx = LEAD_HIGH;
               else
                  err_nx = 1'b1;
            end
         end
         LEAD_HIGH: begin
            if (ir_fall) begin
               if (in_win(cnt32, LEAD_HI_MIN, LEAD_HI_MAX, CYC_PER_US)) begin
                  state_nx = BIT_LOW;
                  idx_nx   = 5'd0;
               end else if (in_win(cnt32, RPT_HI_MIN, RPT_HI_MAX, CYC_PER_US))
                  state_nx = RPT_LOW;
               else
                  err_nx = 1'b1;
            end
         end
         BIT_LOW: begin
            if (ir_rise) begin
               if (in_win(cnt32, BURST_MIN, BURST_MAX, CYC_PER_US))
                  state_nx = BIT_HIGH;
               else
                  err_nx = 1'b1;
            end
         end
         BIT_HIGH: begin
            // The space length carries the bit; first bit received ends up in sh[0].
            if (ir_fall) begin
               if (in_win(cnt32, BURST_MIN, BURST_MAX, CYC_PER_US) ||
                   in_win(cnt32, ONE_HI_MIN, ONE_HI_MAX, CYC_PER_US)) begin
                  sh_nx = {in_win(cnt32, ONE_HI_MIN, ONE_HI_MAX, CYC_PER_US), sh[31:1]};
                  if (idx == 5'd31)
                     state_nx = STOP_LOW;
                  else begin
                     idx_nx   = idx + 5'd1;
                     state_nx = BIT_LOW;
                  end
               end else
                  err_nx = 1'b1;
            end
         end
         STOP_LOW: begin
            if (ir_rise) begin
               if (in_win(cnt32, BURST_MIN, BURST_MAX, CYC_PER_US) &&
                   (CHECK_INV == 0 || inv_ok)) begin
                  load     = 1'b1;
                  valid_nx = 1'b1;
                  state_nx = IDLE;
               end else
                  err_nx = 1'b1;
            end
         end
         RPT_LOW: begin
            if (ir_rise) begin
               if (in_win(cnt32, BURST_MIN, BURST_MAX, CYC_PER_US)) begin
                  rpt_nx   = held;
                  state_nx = IDLE;
               end else
                  err_nx = 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (state != IDLE && !ir_fall && !ir_rise && timeout)
         err_nx = 1'b1;
      // An aborting fall lands in IDLE and is not taken as a new leader.
      if (err_nx) begin
         state_nx = IDLE;
         idx_nx   = 5'd0;
      end
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state   <= IDLE;
         sh      <= '0;
         idx     <= '0;
         held    <= 1'b0;
         oDATA   <= '0;
         oVALID  <= 1'b0;
         oREPEAT <= 1'b0;
         oERR    <= 1'b0;
         oBUSY   <= 1'b0;
      end else begin
         state   <= state_nx;
         sh      <= sh_nx;
         idx     <= idx_nx;
         oVALID  <= valid_nx;
         oREPEAT <= rpt_nx;
         oERR    <= err_nx;
         oBUSY   <= (state_nx != IDLE);
         if (load) begin
            oDATA <= sh;
            held  <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Directed bench for nec_ir_receiver; two instances share the pin, one with
// complement checking and one without. One microsecond = one clock here.
module tb_nec_ir_receiver;

   logic        iCLK, iRST, iIRDA;
   logic [31:0] d0, d1;
   logic        v0_o, r0_o, e0_o, b0_o;
   logic        v1_o, r1_o, e1_o, b1_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0, v0 = 0, r0 = 0, e0 = 0, v1 = 0, r1 = 0, e1 = 0;
   int multi_hi = 0, e0_cyc = 0;

   nec_ir_receiver #(.CYC_PER_US(1), .CHECK_INV(1), .CNT_W(20)) dut (
      .iCLK(iCLK), .iRST(iRST), .iIRDA(iIRDA), .oDATA(d0),
      .oVALID(v0_o), .oREPEAT(r0_o), .oERR(e0_o), .oBUSY(b0_o));

   nec_ir_receiver #(.CYC_PER_US(1), .CHECK_INV(0), .CNT_W(20)) dut_x (
      .iCLK(iCLK), .iRST(iRST), .iIRDA(iIRDA), .oDATA(d1),
      .oVALID(v1_o), .oREPEAT(r1_o), .oERR(e1_o), .oBUSY(b1_o));

   // clock / reset
   initial iCLK = 1'b0;
   always #10 iCLK = ~iCLK;

   // strobe monitor, sampled on the falling edge
   always @(negedge iCLK) begin
      cyc++;
      if (v0_o) v0++;
      if (r0_o) r0++;
      if (e0_o) begin e0++; e0_cyc = cyc; end
      if (v1_o) v1++;
      if (r1_o) r1++;
      if (e1_o) e1++;
      if (int'(v0_o) + int'(r0_o) + int'(e0_o) > 1) multi_hi++;
      if (int'(v1_o) + int'(r1_o) + int'(e1_o) > 1) multi_hi++;
   end

   // driver tasks
   task automatic drive(input logic lvl, input int n);
      iIRDA = lvl;
      repeat (n) @(negedge iCLK);
   endtask

   task automatic send_bits(input logic [31:0] w, input int n,
                            input int bl, input int b0, input int b1);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, bl);
         drive(1'b1, w[i] ? b1 : b0);
      end
   endtask

   task automatic send_frame(input logic [31:0] w, input int ll, input int lh,
                             input int bl, input int b0, input int b1, input int st);
      drive(1'b0, ll);
      drive(1'b1, lh);
      send_bits(w, 32, bl, b0, b1);
      drive(1'b0, st);
      drive(1'b1, 50);
   endtask

   task automatic send_repeat();
      drive(1'b0, 9000);
      drive(1'b1, 2250);
      drive(1'b0, 560);
      drive(1'b1, 50);
   endtask

   // tests
   task automatic test_reset();
      iRST = 1'b1;
      iIRDA = 1'b1;
      repeat (3) @(negedge iCLK);
      n_tests++;
      if (d0 !== 32'h0 || d1 !== 32'h0) begin
         n_fail++; $display("FAIL reset_data: got %h/%h expected 0", d0, d1);
      end
      n_tests++;
      if ({v0_o, r0_o, e0_o, b0_o, v1_o, r1_o, e1_o, b1_o} !== 8'h00) begin
         n_fail++; $display("FAIL reset_strobes: got %b expected 00000000",
                            {v0_o, r0_o, e0_o, b0_o, v1_o, r1_o, e1_o, b1_o});
      end
      iRST = 1'b0;
      repeat (10) @(negedge iCLK);
   endtask

   task automatic test_repeat_after_reset();
      int br = r0, be = e0;
      send_repeat();
      n_tests++;
      if (r0 - br !== 0 || e0 - be !== 0) begin
         n_fail++; $display("FAIL rpt_no_held: got rpt=%0d err=%0d expected 0/0", r0 - br, e0 - be);
      end
      n_tests++;
      if (d0 !== 32'h0) begin
         n_fail++; $display("FAIL rpt_no_held_data: got %h expected 0", d0);
      end
   endtask

   task automatic test_nominal_frame();
      int bv = v0, be = e0;
      send_frame(32'hBB44FF00, 9000, 4500, 560, 560, 1690, 560);
      n_tests++;
      if (v0 - bv !== 1 || e0 - be !== 0) begin
         n_fail++; $display("FAIL nominal_strobes: got valid=%0d err=%0d expected 1/0", v0 - bv, e0 - be);
      end
      n_tests++;
      if (d0 !== 32'hBB44FF00) begin
         n_fail++; $display("FAIL nominal_data: got %h expected bb44ff00", d0);
      end
      n_tests++;
      if (b0_o !== 1'b0) begin
         n_fail++; $display("FAIL nominal_busy: got %b expected 0", b0_o);
      end
   endtask

   task automatic test_repeat();
      int br = r0, bv = v0;
      drive(1'b1, 3000);
      send_repeat();
      n_tests++;
      if (r0 - br !== 1 || v0 - bv !== 0) begin
         n_fail++; $display("FAIL repeat_strobe: got rpt=%0d valid=%0d expected 1/0", r0 - br, v0 - bv);
      end
      n_tests++;
      if (d0 !== 32'hBB44FF00) begin
         n_fail++; $display("FAIL repeat_data: got %h expected bb44ff00", d0);
      end
   endtask

   task automatic test_bad_leader();
      int be = e0, bv = v0;
      drive(1'b0, 7000);
      drive(1'b1, 500);
      n_tests++;
      if (e0 - be !== 1 || v0 - bv !== 0) begin
         n_fail++; $display("FAIL short_leader: got err=%0d valid=%0d expected 1/0", e0 - be, v0 - bv);
      end
   endtask

   task automatic test_timeout();
      int be = e0, be1 = e1, bv = v0, t_fall;
      drive(1'b0, 9000);
      drive(1'b1, 4500);
      send_bits(32'hBB44FF00, 12, 560, 560, 1690);
      iIRDA = 1'b0;
      t_fall = cyc;
      repeat (20000) @(negedge iCLK);
      drive(1'b1, 100);
      n_tests++;
      if (e0 - be !== 1 || e1 - be1 !== 1 || v0 - bv !== 0) begin
         n_fail++; $display("FAIL timeout_err: got err=%0d/%0d valid=%0d expected 1/1/0",
                            e0 - be, e1 - be1, v0 - bv);
      end
      // ~12000 us of silence plus synchroniser and output register latency
      n_tests++;
      if (e0_cyc - t_fall < 11995 || e0_cyc - t_fall > 12015) begin
         n_fail++; $display("FAIL timeout_time: got %0d cycles expected 11995..12015", e0_cyc - t_fall);
      end
      n_tests++;
      if (d0 !== 32'hBB44FF00) begin
         n_fail++; $display("FAIL timeout_data: got %h expected bb44ff00", d0);
      end
   endtask

   task automatic test_edge_timing_frame();
      int bv = v0, be = e0;
      // every phase sits 10 us inside its window
      send_frame(32'hCB34ED12, 8010, 4010, 410, 690, 1410, 690);
      n_tests++;
      if (v0 - bv !== 1 || e0 - be !== 0) begin
         n_fail++; $display("FAIL tight_strobes: got valid=%0d err=%0d expected 1/0", v0 - bv, e0 - be);
      end
      n_tests++;
      if (d0 !== 32'hCB34ED12) begin
         n_fail++; $display("FAIL tight_data: got %h expected cb34ed12", d0);
      end
   endtask

   task automatic test_complement();
      int bv = v0, be = e0, bv1 = v1, be1 = e1;
      send_frame(32'hBA44FF00, 9000, 4500, 560, 560, 1690, 560);
      n_tests++;
      if (e0 - be !== 1 || v0 - bv !== 0) begin
         n_fail++; $display("FAIL inv_checked: got err=%0d valid=%0d expected 1/0", e0 - be, v0 - bv);
      end
      n_tests++;
      if (d0 !== 32'hCB34ED12) begin
         n_fail++; $display("FAIL inv_checked_data: got %h expected cb34ed12", d0);
      end
      n_tests++;
      if (v1 - bv1 !== 1 || e1 - be1 !== 0) begin
         n_fail++; $display("FAIL inv_ext: got valid=%0d err=%0d expected 1/0", v1 - bv1, e1 - be1);
      end
      n_tests++;
      if (d1 !== 32'hBA44FF00) begin
         n_fail++; $display("FAIL inv_ext_data: got %h expected ba44ff00", d1);
      end
   endtask

   task automatic test_mid_reset();
      int bv, be;
      drive(1'b0, 9000);
      drive(1'b1, 4500);
      send_bits(32'hBB44FF00, 20, 560, 560, 1690);
      drive(1'b0, 200);
      iRST = 1'b1;
      #1;
      n_tests++;
      if (d0 !== 32'h0 || {v0_o, r0_o, e0_o, b0_o} !== 4'h0) begin
         n_fail++; $display("FAIL midreset_outputs: got data=%h strobes=%b expected 0/0000",
                            d0, {v0_o, r0_o, e0_o, b0_o});
      end
      iIRDA = 1'b1;
      repeat (5) @(negedge iCLK);
      iRST = 1'b0;
      repeat (20) @(negedge iCLK);
      bv = v0;
      be = e0;
      send_frame(32'hA55A5AA5, 9000, 4500, 560, 560, 1690, 560);
      n_tests++;
      if (v0 - bv !== 1 || e0 - be !== 0) begin
         n_fail++; $display("FAIL postreset_strobes: got valid=%0d err=%0d expected 1/0", v0 - bv, e0 - be);
      end
      n_tests++;
      if (d0 !== 32'hA55A5AA5) begin
         n_fail++; $display("FAIL postreset_data: got %h expected a55a5aa5", d0);
      end
   endtask

   task automatic test_exclusive();
      n_tests++;
      if (multi_hi !== 0) begin
         n_fail++; $display("FAIL strobe_exclusive: got %0d overlapping cycles expected 0", multi_hi);
      end
   endtask

   initial begin
      iRST = 1'b1;
      iIRDA = 1'b1;
      test_reset();
      test_repeat_after_reset();
      test_nominal_frame();
      test_repeat();
      test_bad_leader();
      test_timeout();
      test_edge_timing_frame();
      test_complement();
      test_mid_reset();
      test_exclusive();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
